// File: rtl/exc_pkg.sv
// Shared cause codes, FSM state encoding and default handler vector for the exception controller.
package exc_pkg;

   localparam int unsigned CAUSE_W = 3;
   localparam int unsigned CNT_W   = 4;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE  = 3'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_IADDR = 3'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_OVF   = 3'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_DIV0  = 3'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_CTRL  = 3'd4;
   localparam logic [CAUSE_W-1:0] CAUSE_W20   = 3'd5;

   localparam logic [31:0] HANDLER_VEC_DEF = 32'h0000_0080;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FLUSH   = 3'd1,
      REDIR_H = 3'd2,
      HANDLER = 3'd3,
      REDIR_E = 3'd4
   } state_e;

endpackage

// File: rtl/exception_controller_if.sv
// Pipeline-side bundle: exception causes and PC in, flush/redirect/status out.
interface exception_controller_if
   import exc_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
);

   logic               ec_overflow;
   logic               ec_invalid_addr;
   logic               ec_div_zero;
   logic               ec_control;
   logic               ec_write2_0;
   logic [ADDR_W-1:0]  ec_pc;
   logic               ec_eret;
   logic               ec_redirect_ack;

   logic               ec_flush;
   logic               ec_redirect;
   logic [ADDR_W-1:0]  ec_redirect_pc;
   logic [CAUSE_W-1:0] ec_cause;
   logic [ADDR_W-1:0]  ec_epc;
   logic               ec_exl;
   logic               ec_busy;
   logic               ec_dropped;

   // Pipeline / fetch side.
   modport master (
      output ec_overflow, ec_invalid_addr, ec_div_zero, ec_control, ec_write2_0,
      output ec_pc, ec_eret, ec_redirect_ack,
      input  ec_flush, ec_redirect, ec_redirect_pc, ec_cause, ec_epc,
      input  ec_exl, ec_busy, ec_dropped
   );

   // Controller side.
   modport slave (
      input  ec_overflow, ec_invalid_addr, ec_div_zero, ec_control, ec_write2_0,
      input  ec_pc, ec_eret, ec_redirect_ack,
      output ec_flush, ec_redirect, ec_redirect_pc, ec_cause, ec_epc,
      output ec_exl, ec_busy, ec_dropped
   );

endinterface

// File: rtl/exc_cause_encoder.sv
// Fixed-priority encoder of the five raw exception causes.
module exc_cause_encoder
   import exc_pkg::*;
(
   input  logic               overflow,
   input  logic               invalid_addr,
   input  logic               div_zero,
   input  logic               control,
   input  logic               write2_0,
   output logic [CAUSE_W-1:0] cause_c,
   output logic               any_c
);

   // invalid_addr > overflow > div_zero > control > write2_0
   always_comb begin
      cause_c = CAUSE_NONE;
      if (invalid_addr)  cause_c = CAUSE_IADDR;
      else if (overflow) cause_c = CAUSE_OVF;
      else if (div_zero) cause_c = CAUSE_DIV0;
      else if (control)  cause_c = CAUSE_CTRL;
      else if (write2_0) cause_c = CAUSE_W20;
      any_c = overflow | invalid_addr | div_zero | control | write2_0;
   end

endmodule

// File: rtl/exception_controller.sv
// Exception recovery sequencer: accept, flush, redirect to handler, return to EPC on ERET.
module exception_controller
   import exc_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] HANDLER_VEC  = ADDR_W'(HANDLER_VEC_DEF),
   parameter int unsigned       FLUSH_CYCLES = 2
)(
   input  logic                   clk,
   input  logic                   rst_n,
   exception_controller_if.slave  bus
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [ADDR_W-1:0]  epc_q, epc_d;
   logic               exl_q, exl_d;
   logic               flush_q, flush_d;
   logic               redirect_q, redirect_d;
   logic               busy_q, busy_d;
   logic               dropped_q, dropped_d;

   logic [CAUSE_W-1:0] enc_cause_c;
   logic               enc_any_c;

   exc_cause_encoder u_enc (
      .overflow     (bus.ec_overflow),
      .invalid_addr (bus.ec_invalid_addr),
      .div_zero     (bus.ec_div_zero),
      .control      (bus.ec_control),
      .write2_0     (bus.ec_write2_0),
      .cause_c      (enc_cause_c),
      .any_c        (enc_any_c)
   );

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cause_q    <= '0;
         epc_q      <= '0;
         exl_q      <= 1'b0;
         flush_q    <= 1'b0;
         redirect_q <= 1'b0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         exl_q      <= exl_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         busy_q     <= busy_d;
         dropped_q  <= dropped_d;
      end
   end

   // Next-state logic; registered outputs are decoded from the next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      epc_d   = epc_q;
      exl_d   = exl_q;

      case (state_q)
         IDLE: begin
            if (enc_any_c) begin
               cause_d = enc_cause_c;
               epc_d   = bus.ec_pc;
               exl_d   = 1'b1;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (cnt_q == '0) state_d = REDIR_H;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         REDIR_H: begin
            if (bus.ec_redirect_ack) state_d = HANDLER;
         end
         HANDLER: begin
            if (bus.ec_eret) state_d = REDIR_E;
         end
         REDIR_E: begin
            if (bus.ec_redirect_ack) begin
               exl_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      flush_d    = (state_d == FLUSH);
      redirect_d = (state_d == REDIR_H) || (state_d == REDIR_E);
      busy_d     = (state_d != IDLE);
      dropped_d  = (state_q != IDLE) && enc_any_c;
   end

   // Redirect target is a mux of registered state only.
   always_comb begin
      bus.ec_redirect_pc = '0;
      if (state_q == REDIR_H)      bus.ec_redirect_pc = HANDLER_VEC;
      else if (state_q == REDIR_E) bus.ec_redirect_pc = epc_q;
   end

   assign bus.ec_flush    = flush_q;
   assign bus.ec_redirect = redirect_q;
   assign bus.ec_cause    = cause_q;
   assign bus.ec_epc      = epc_q;
   assign bus.ec_exl      = exl_q;
   assign bus.ec_busy     = busy_q;
   assign bus.ec_dropped  = dropped_q;

endmodule

// File: tb/tb_exception_controller.sv
// Randomized and directed bench for exception_controller against a phase-counting reference model.
module tb_exception_controller;

   localparam logic [31:0] HV = 32'h0000_0080;
   localparam int          FC = 2;

   // c[0]=overflow c[1]=invalid_addr c[2]=div_zero c[3]=control c[4]=write2_0
   typedef struct packed {
      logic        rst_n;
      logic [4:0]  c;
      logic [31:0] pc;
      logic        eret;
      logic        ack;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   exception_controller_if #(.ADDR_W(32)) bus ();

   exception_controller #(.ADDR_W(32), .HANDLER_VEC(HV), .FLUSH_CYCLES(FC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [71:0] obs;
   assign obs = {bus.ec_flush, bus.ec_redirect, bus.ec_redirect_pc, bus.ec_cause,
                 bus.ec_epc, bus.ec_exl, bus.ec_busy, bus.ec_dropped};

   // Reference model: remaining flush cycles plus three "waiting" flags.
   int          m_flush_left = 0;
   logic        m_wait_h = 0, m_handler = 0, m_wait_e = 0;
   logic        m_exl = 0, m_dropped = 0;
   logic [2:0]  m_cause = 0;
   logic [31:0] m_epc = 0;

   function automatic logic [2:0] prio(input logic [4:0] c);
      if (c[1]) return 3'd1;
      if (c[0]) return 3'd2;
      if (c[2]) return 3'd3;
      if (c[3]) return 3'd4;
      if (c[4]) return 3'd5;
      return 3'd0;
   endfunction

   function automatic logic m_busy();
      return (m_flush_left > 0) || m_wait_h || m_handler || m_wait_e;
   endfunction

   function automatic logic [71:0] exp_v();
      logic [31:0] rpc;
      rpc = m_wait_h ? HV : (m_wait_e ? m_epc : 32'h0);
      return {(m_flush_left > 0), (m_wait_h || m_wait_e), rpc, m_cause, m_epc,
              m_exl, m_busy(), m_dropped};
   endfunction

   task automatic model_edge(input stim_t s);
      logic busy;
      if (!s.rst_n) begin
         m_flush_left = 0; m_wait_h = 0; m_handler = 0; m_wait_e = 0;
         m_exl = 0; m_dropped = 0; m_cause = 0; m_epc = 0;
      end else begin
         busy = m_busy();
         m_dropped = busy && (s.c != 5'b0);
         if (!busy && s.c != 5'b0) begin
            m_cause = prio(s.c); m_epc = s.pc; m_exl = 1; m_flush_left = FC;
         end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) m_wait_h = 1;
         end else if (m_wait_h && s.ack) begin
            m_wait_h = 0; m_handler = 1;
         end else if (m_handler && s.eret) begin
            m_handler = 0; m_wait_e = 1;
         end else if (m_wait_e && s.ack) begin
            m_wait_e = 0; m_exl = 0;
         end
      end
   endtask

   function automatic stim_t mk(input logic r, input logic [4:0] c, input logic [31:0] pc,
                                input logic e, input logic a);
      stim_t s;
      s.rst_n = r; s.c = c; s.pc = pc; s.eret = e; s.ack = a;
      return s;
   endfunction

   // Drive one cycle, advance the model on the same edge, settle past the edge.
   task automatic cyc(input stim_t s);
      rst_n               = s.rst_n;
      bus.ec_overflow     = s.c[0];
      bus.ec_invalid_addr = s.c[1];
      bus.ec_div_zero     = s.c[2];
      bus.ec_control      = s.c[3];
      bus.ec_write2_0     = s.c[4];
      bus.ec_pc           = s.pc;
      bus.ec_eret         = s.eret;
      bus.ec_redirect_ack = s.ack;
      @(posedge clk);
      model_edge(s);
      #1;
   endtask

   task automatic test_reset();
      stim_t q[$];
      q.push_back(mk(0, 5'b11111, 32'hdead_beef, 1, 1));
      q.push_back(mk(0, 5'b00001, 32'h1234_5678, 0, 1));
      foreach (q[i]) begin
         cyc(q[i]);
         n_chk++;
         if (obs !== 72'h0) begin
            n_fail++; $display("FAIL reset[%0d]: got %h expected 0", i, obs);
         end
      end
   endtask

   task automatic test_overflow();
      stim_t q[$];
      int nf = 0, nr = 0;
      logic [31:0] rpc = 0;
      q.push_back(mk(0, 5'b0, 32'h0, 0, 1));
      q.push_back(mk(1, 5'b00001, 32'h40, 0, 1));
      repeat (4) q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      foreach (q[i]) begin
         cyc(q[i]);
         n_chk++;
         if (obs !== exp_v()) begin
            n_fail++; $display("FAIL overflow[%0d]: got %h expected %h", i, obs, exp_v());
         end
         if (bus.ec_flush) nf++;
         if (bus.ec_redirect) begin nr++; rpc = bus.ec_redirect_pc; end
      end
      n_chk++; if (nf != 2) begin n_fail++; $display("FAIL overflow_flush_cycles: got %0d expected 2", nf); end
      n_chk++; if (nr != 1) begin n_fail++; $display("FAIL overflow_redirect_cycles: got %0d expected 1", nr); end
      n_chk++; if (rpc !== 32'h80) begin n_fail++; $display("FAIL overflow_redirect_pc: got %h expected 80", rpc); end
      n_chk++; if (bus.ec_cause !== 3'd2) begin n_fail++; $display("FAIL overflow_cause: got %0d expected 2", bus.ec_cause); end
      n_chk++; if (bus.ec_epc !== 32'h40) begin n_fail++; $display("FAIL overflow_epc: got %h expected 40", bus.ec_epc); end
      n_chk++; if (bus.ec_exl !== 1'b1) begin n_fail++; $display("FAIL overflow_exl: got %b expected 1", bus.ec_exl); end
      cyc(mk(1, 5'b0, 32'h0, 1, 1));
      n_chk++; if (bus.ec_redirect_pc !== 32'h40) begin n_fail++; $display("FAIL overflow_return_pc: got %h expected 40", bus.ec_redirect_pc); end
      cyc(mk(1, 5'b0, 32'h0, 0, 1));
      n_chk++; if ({bus.ec_exl, bus.ec_busy, bus.ec_epc} !== {2'b00, 32'h40}) begin
         n_fail++; $display("FAIL overflow_after_return: got exl=%b busy=%b epc=%h expected 0 0 40", bus.ec_exl, bus.ec_busy, bus.ec_epc);
      end
   endtask

   task automatic test_priority();
      logic [4:0] pats [3] = '{5'b11111, 5'b10010, 5'b11000};
      logic [2:0] want [3] = '{3'd1, 3'd1, 3'd4};
      foreach (pats[p]) begin
         stim_t q[$];
         q.push_back(mk(1, pats[p], 32'h1000 + 32'(p) * 4, 0, 1));
         repeat (3) q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
         q.push_back(mk(1, 5'b0, 32'h0, 1, 1));
         q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
         foreach (q[i]) begin
            cyc(q[i]);
            n_chk++;
            if (obs !== exp_v()) begin
               n_fail++; $display("FAIL priority%0d[%0d]: got %h expected %h", p, i, obs, exp_v());
            end
         end
         n_chk++;
         if (bus.ec_cause !== want[p]) begin
            n_fail++; $display("FAIL priority%0d_cause: got %0d expected %0d", p, bus.ec_cause, want[p]);
         end
      end
   endtask

   task automatic test_masking();
      stim_t q[$];
      int nd = 0, nhold = 0;
      logic [31:0] pc = {$urandom_range(1, 1000), 2'b00};
      q.push_back(mk(1, 5'b00001, pc, 0, 1));
      repeat (4) q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      q.push_back(mk(1, 5'b00100, 32'hffff_0000, 0, 0));
      q.push_back(mk(1, 5'b0, 32'h0, 0, 0));
      q.push_back(mk(1, 5'b0, 32'h0, 1, 0));
      repeat (3) q.push_back(mk(1, 5'b0, 32'h0, 0, 0));
      q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      foreach (q[i]) begin
         cyc(q[i]);
         n_chk++;
         if (obs !== exp_v()) begin
            n_fail++; $display("FAIL masking[%0d]: got %h expected %h", i, obs, exp_v());
         end
         if (bus.ec_dropped) nd++;
         if (i >= 8 && i <= 10 && bus.ec_redirect && bus.ec_redirect_pc == pc) nhold++;
      end
      n_chk++; if (nd != 1) begin n_fail++; $display("FAIL masking_dropped_pulses: got %0d expected 1", nd); end
      n_chk++; if (nhold != 3) begin n_fail++; $display("FAIL masking_eret_hold: got %0d expected 3", nhold); end
      n_chk++; if ({bus.ec_cause, bus.ec_epc, bus.ec_exl} !== {3'd2, pc, 1'b0}) begin
         n_fail++; $display("FAIL masking_final: got cause=%0d epc=%h exl=%b expected 2 %h 0", bus.ec_cause, bus.ec_epc, bus.ec_exl, pc);
      end
   endtask

   task automatic test_ignored();
      stim_t q[$];
      int nf = 0;
      q.push_back(mk(0, 5'b0, 32'h0, 0, 0));
      q.push_back(mk(1, 5'b0, 32'h0, 1, 0));
      q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      q.push_back(mk(1, 5'b0, 32'h0, 1, 1));
      foreach (q[i]) begin
         cyc(q[i]);
         n_chk++;
         if (obs !== 72'h0) begin
            n_fail++; $display("FAIL ignored_idle[%0d]: got %h expected 0", i, obs);
         end
      end
      q.delete();
      q.push_back(mk(1, 5'b01000, 32'h200, 0, 0));
      q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      q.push_back(mk(1, 5'b0, 32'h0, 1, 1));
      q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      foreach (q[i]) begin
         cyc(q[i]);
         n_chk++;
         if (obs !== exp_v()) begin
            n_fail++; $display("FAIL ignored_flush[%0d]: got %h expected %h", i, obs, exp_v());
         end
         if (bus.ec_flush) nf++;
      end
      n_chk++; if (nf != 2) begin n_fail++; $display("FAIL ignored_flush_len: got %0d expected 2", nf); end
   endtask

   task automatic test_reset_mid();
      stim_t q[$];
      q.push_back(mk(1, 5'b00100, 32'h300, 0, 0));
      repeat (3) q.push_back(mk(1, 5'b0, 32'h0, 0, 0));
      foreach (q[i]) begin
         cyc(q[i]);
         n_chk++;
         if (obs !== exp_v()) begin
            n_fail++; $display("FAIL reset_mid[%0d]: got %h expected %h", i, obs, exp_v());
         end
      end
      cyc(mk(0, 5'b0, 32'h0, 0, 1));
      n_chk++; if (obs !== 72'h0) begin n_fail++; $display("FAIL reset_mid_clear: got %h expected 0", obs); end
      cyc(mk(1, 5'b01000, 32'h100, 0, 1));
      n_chk++; if ({bus.ec_cause, bus.ec_epc, bus.ec_flush, bus.ec_exl} !== {3'd4, 32'h100, 2'b11}) begin
         n_fail++; $display("FAIL reset_mid_accept: got %h expected cause 4 epc 100 flush exl", obs);
      end
      repeat (3) cyc(mk(1, 5'b0, 32'h0, 0, 1));
      cyc(mk(1, 5'b0, 32'h0, 1, 1));
      cyc(mk(1, 5'b0, 32'h0, 0, 1));
      n_chk++; if (obs !== exp_v()) begin n_fail++; $display("FAIL reset_mid_return: got %h expected %h", obs, exp_v()); end
   endtask

   task automatic test_back_to_back();
      stim_t q[$];
      q.push_back(mk(1, 5'b00001, 32'h500, 0, 1));
      repeat (3) q.push_back(mk(1, 5'b0, 32'h0, 0, 1));
      foreach (q[i]) begin
         cyc(q[i]);
         n_chk++;
         if (obs !== exp_v()) begin
            n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, exp_v());
         end
      end
      cyc(mk(1, 5'b01000, 32'h900, 1, 0));
      n_chk++; if ({bus.ec_redirect, bus.ec_redirect_pc, bus.ec_dropped, bus.ec_cause, bus.ec_epc} !== {1'b1, 32'h500, 1'b1, 3'd2, 32'h500}) begin
         n_fail++; $display("FAIL eret_and_cause: got %h expected redirect to 500 with drop", obs);
      end
      cyc(mk(1, 5'b0, 32'h0, 0, 1));
      n_chk++; if ({bus.ec_busy, bus.ec_exl} !== 2'b00) begin
         n_fail++; $display("FAIL back_to_back_idle: got busy=%b exl=%b expected 0 0", bus.ec_busy, bus.ec_exl);
      end
      cyc(mk(1, 5'b10000, 32'h604, 0, 1));
      n_chk++; if ({bus.ec_cause, bus.ec_epc, bus.ec_exl, bus.ec_flush, bus.ec_dropped} !== {3'd5, 32'h604, 3'b110}) begin
         n_fail++; $display("FAIL back_to_back_accept: got %h expected cause 5 epc 604", obs);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         stim_t s;
         logic [4:0] c;
         for (int b = 0; b < 5; b++) c[b] = ($urandom_range(0, 9) == 0);
         s = mk(($urandom_range(0, 63) != 0), c, {$urandom(), 2'b00} >> 2 << 2,
                ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
         cyc(s);
         n_chk++;
         if (obs !== exp_v()) begin
            n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_v());
         end
         if (bus.ec_flush && bus.ec_redirect) begin
            n_fail++; $display("FAIL random_flush_redirect[%0d]: got both high expected exclusive", i);
         end
      end
   endtask

   initial begin
      bus.ec_overflow = 0; bus.ec_invalid_addr = 0; bus.ec_div_zero = 0;
      bus.ec_control = 0; bus.ec_write2_0 = 0; bus.ec_pc = '0;
      bus.ec_eret = 0; bus.ec_redirect_ack = 0;
      test_reset();
      test_overflow();
      test_priority();
      test_masking();
      test_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 1ms");
      $fatal(1);
   end

endmodule
